// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a multi-cycle shift-add unsigned multiplier.
// Single-cycle units finish on the accepting edge. Multiply holds the block
// busy for WIDTH cycles, then registers the low or high half of the product.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  output logic             ready_out,
  input  logic [2:0]       unit_sel_in,
  input  logic             op_sel_in,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] src_in,
  output logic [WIDTH-1:0] res_out,
  output logic             done_out,
  output logic             zero_out,
  output logic             carry_out,
  output logic             neg_out
);

  localparam int SHW = $clog2(WIDTH);
  localparam int PW  = 2 * WIDTH;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             hi_q, hi_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   shr;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [PW-1:0]    prod_nxt;
  logic [WIDTH-1:0] mul_res;

  // Single-cycle units computed straight from the inputs.
  // Shifts run one bit wider than the operand so the last bit shifted out
  // lands in the extra position; amount 0 leaves that position at 0.
  always_comb begin
    shamt     = src_in[SHW-1:0];
    sum       = {1'b0, acc_in} + {1'b0, (op_sel_in ? ~src_in : src_in)}
                + {{WIDTH{1'b0}}, op_sel_in};
    shl       = {1'b0, acc_in} << shamt;
    shr       = {acc_in, 1'b0} >> shamt;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (unit_sel_in)
      3'b000: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      3'b001: alu_res = op_sel_in ? ~(acc_in & src_in) : (acc_in & src_in);
      3'b010: begin
        if (op_sel_in) begin
          alu_res   = shr[WIDTH:1];
          alu_carry = shr[0];
        end else begin
          alu_res   = shl[WIDTH-1:0];
          alu_carry = shl[WIDTH];
        end
      end
      3'b011: alu_res = src_in;
      3'b100: alu_res = acc_in | src_in;
      3'b101: alu_res = acc_in ^ src_in;
      3'b111: alu_res = acc_in;
      default: alu_res = '0;
    endcase
  end

  // One shift-add multiply step and the half selected for the result.
  always_comb begin
    prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
    mul_res  = hi_q ? prod_nxt[PW-1:WIDTH] : prod_nxt[WIDTH-1:0];
  end

  // Next-state: accept in IDLE, iterate in MUL, register results on completion.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    done_d   = 1'b0;
    zero_d   = zero_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          if (unit_sel_in == 3'b110) begin
            state_d  = MUL;
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, acc_in};
            mplier_d = src_in;
            cnt_d    = '0;
            hi_d     = op_sel_in;
          end else begin
            res_d   = alu_res;
            done_d  = 1'b1;
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
            neg_d   = alu_res[WIDTH-1];
          end
        end
      end
      MUL: begin
        prod_d   = prod_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = IDLE;
          res_d   = mul_res;
          done_d  = 1'b1;
          zero_d  = (mul_res == '0);
          carry_d = 1'b0;
          neg_d   = mul_res[WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      res_q    <= '0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
    end
  end

  assign ready_out = (state_q == IDLE);
  assign res_out   = res_q;
  assign done_out  = done_q;
  assign zero_out  = zero_q;
  assign carry_out = carry_q;
  assign neg_out   = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8 and WIDTH=16. Expected {res,zero,carry,neg}
// entries are queued when an op is issued and popped when done_out appears.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic       start8 = 1'b0, op8 = 1'b0;
  logic [2:0] unit8 = '0;
  logic [7:0] acc8 = '0, src8 = '0, res8;
  logic       ready8, done8, z8, c8, n8;

  logic        start16 = 1'b0, op16 = 1'b0;
  logic [2:0]  unit16 = '0;
  logic [15:0] acc16 = '0, src16 = '0, res16;
  logic        ready16, done16, z16, c16, n16;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk_in(clk), .rst_in(rst), .start_in(start8), .ready_out(ready8),
    .unit_sel_in(unit8), .op_sel_in(op8), .acc_in(acc8), .src_in(src8),
    .res_out(res8), .done_out(done8), .zero_out(z8), .carry_out(c8), .neg_out(n8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk_in(clk), .rst_in(rst), .start_in(start16), .ready_out(ready16),
    .unit_sel_in(unit16), .op_sel_in(op16), .acc_in(acc16), .src_in(src16),
    .res_out(res16), .done_out(done16), .zero_out(z16), .carry_out(c16), .neg_out(n16)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] sb8[$];
  logic [18:0] sb16[$];

  // Reference behaviour for WIDTH=8, written independently of the RTL.
  function automatic logic [10:0] model8(input logic [2:0] u, input logic op,
                                         input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  s;
    logic [7:0]  r;
    logic        c;
    logic [15:0] p;
    int          sh;
    r = '0;
    c = 1'b0;
    case (u)
      3'd0: begin
        if (op) begin
          r = a - b;
          c = (a >= b);
        end else begin
          s = {1'b0, a} + {1'b0, b};
          r = s[7:0];
          c = s[8];
        end
      end
      3'd1: r = op ? ~(a & b) : (a & b);
      3'd2: begin
        sh = int'(b[2:0]);
        r  = a;
        for (int i = 0; i < sh; i++) begin
          if (op) begin
            c = r[0];
            r = r >> 1;
          end else begin
            c = r[7];
            r = r << 1;
          end
        end
      end
      3'd3: r = b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: begin
        p = 16'(a) * 16'(b);
        r = op ? p[15:8] : p[7:0];
      end
      default: r = a;
    endcase
    return {r, (r == 8'h00), c, r[7]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({ready8, done8, res8, z8, c8, n8} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      n_err++;
      $display("FAIL reset8: got rdy=%b done=%b res=%h zcn=%b%b%b want rdy=1 done=0 res=00 zcn=000",
               ready8, done8, res8, z8, c8, n8);
    end
    n_cmp++;
    if ({ready16, done16, res16, z16, c16, n16} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      n_err++;
      $display("FAIL reset16: got rdy=%b done=%b res=%h zcn=%b%b%b want rdy=1 done=0 res=0000 zcn=000",
               ready16, done16, res16, z16, c16, n16);
    end
  endtask

  // Table entries: {unit, op, acc, src, expected res, expected carry}.
  task automatic test_single_cycle();
    logic [28:0] tab [0:14];
    logic [10:0] exp_v;
    logic [7:0]  er;
    tab = '{
      {3'd0, 1'b0, 8'hF0, 8'h20, 8'h10, 1'b1},
      {3'd0, 1'b1, 8'h03, 8'h05, 8'hFE, 1'b0},
      {3'd0, 1'b1, 8'h05, 8'h05, 8'h00, 1'b1},
      {3'd2, 1'b0, 8'h81, 8'h01, 8'h02, 1'b1},
      {3'd2, 1'b1, 8'h81, 8'h01, 8'h40, 1'b1},
      {3'd2, 1'b1, 8'h81, 8'h03, 8'h10, 1'b0},
      {3'd2, 1'b0, 8'h81, 8'h00, 8'h81, 1'b0},
      {3'd2, 1'b1, 8'h81, 8'h08, 8'h81, 1'b0},
      {3'd1, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0},
      {3'd1, 1'b1, 8'hF0, 8'h3C, 8'hCF, 1'b0},
      {3'd3, 1'b0, 8'h12, 8'hA5, 8'hA5, 1'b0},
      {3'd4, 1'b0, 8'hF0, 8'h0F, 8'hFF, 1'b0},
      {3'd5, 1'b0, 8'hFF, 8'h0F, 8'hF0, 1'b0},
      {3'd7, 1'b0, 8'h00, 8'h55, 8'h00, 1'b0},
      {3'd0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0}
    };
    for (int i = 0; i < 15; i++) begin
      {unit8, op8, acc8, src8, er, exp_v[1]} = tab[i];
      start8 = 1'b1;
      sb8.push_back({er, (er == 8'h00), exp_v[1], er[7]});
      tick();
      start8 = 1'b0;
      n_cmp++;
      if (done8 !== 1'b1) begin
        n_err++;
        $display("FAIL single_done[%0d]: got %b want 1", i, done8);
      end
      exp_v = sb8.pop_front();
      n_cmp++;
      if ({res8, z8, c8, n8} !== exp_v) begin
        n_err++;
        $display("FAIL single_res[%0d]: got res=%h zcn=%b%b%b want res=%h zcn=%b",
                 i, res8, z8, c8, n8, exp_v[10:3], exp_v[2:0]);
      end
    end
  endtask

  task automatic test_mul(input logic [7:0] a, input logic [7:0] b, input logic op,
                          input logic hold, input logic [7:0] er);
    int          lowcnt;
    int          dcnt;
    logic [10:0] exp_v;
    unit8  = 3'd6;
    op8    = op;
    acc8   = a;
    src8   = b;
    start8 = 1'b1;
    sb8.push_back({er, (er == 8'h00), 1'b0, er[7]});
    tick();
    start8 = hold && !ready8;
    lowcnt = 0;
    dcnt   = 0;
    while (!ready8 && lowcnt < 40) begin
      lowcnt++;
      if (done8) dcnt++;
      tick();
      start8 = hold && !ready8;
      acc8   = 8'($urandom);
      src8   = 8'($urandom);
      unit8  = 3'($urandom);
      op8    = 1'($urandom);
    end
    start8 = 1'b0;
    n_cmp++;
    if (lowcnt !== 8) begin
      n_err++;
      $display("FAIL mul_busy %h*%h: got %0d cycles want 8", a, b, lowcnt);
    end
    n_cmp++;
    if (done8 !== 1'b1 || dcnt !== 0) begin
      n_err++;
      $display("FAIL mul_done %h*%h: got done=%b early=%0d want done=1 early=0", a, b, done8, dcnt);
    end
    exp_v = sb8.pop_front();
    n_cmp++;
    if ({res8, z8, c8, n8} !== exp_v) begin
      n_err++;
      $display("FAIL mul_res %h*%h op=%b: got res=%h zcn=%b%b%b want res=%h zcn=%b",
               a, b, op, res8, z8, c8, n8, exp_v[10:3], exp_v[2:0]);
    end
    tick();
    n_cmp++;
    if (done8 !== 1'b0) begin
      n_err++;
      $display("FAIL mul_pulse %h*%h: got done=%b want 0", a, b, done8);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_v;
    for (int i = 0; i < 3; i++) begin
      unit8  = 3'd0;
      op8    = 1'b0;
      acc8   = 8'($urandom);
      src8   = 8'($urandom);
      start8 = 1'b1;
      sb8.push_back(model8(unit8, op8, acc8, src8));
      tick();
      n_cmp++;
      if (done8 !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_done[%0d]: got %b want 1", i, done8);
      end
      exp_v = sb8.pop_front();
      n_cmp++;
      if ({res8, z8, c8, n8} !== exp_v) begin
        n_err++;
        $display("FAIL b2b_res[%0d]: got res=%h zcn=%b%b%b want res=%h zcn=%b",
                 i, res8, z8, c8, n8, exp_v[10:3], exp_v[2:0]);
      end
    end
    start8 = 1'b0;
    tick();
    n_cmp++;
    if (done8 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: got done=%b want 0", done8);
    end
  endtask

  task automatic test_reset_during_mul();
    int dcnt;
    unit8  = 3'd6;
    op8    = 1'b0;
    acc8   = 8'h12;
    src8   = 8'h34;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({ready8, done8, res8, z8, c8, n8} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      n_err++;
      $display("FAIL mul_abort: got rdy=%b done=%b res=%h zcn=%b%b%b want rdy=1 done=0 res=00 zcn=000",
               ready8, done8, res8, z8, c8, n8);
    end
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done8 !== 1'b0 || ready8 !== 1'b1) dcnt++;
    end
    n_cmp++;
    if (dcnt !== 0) begin
      n_err++;
      $display("FAIL mul_abort_quiet: got %0d bad cycles want 0", dcnt);
    end
  endtask

  task automatic test_reset_start_collision();
    unit8  = 3'd0;
    op8    = 1'b0;
    acc8   = 8'h01;
    src8   = 8'h01;
    start8 = 1'b1;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    start8 = 1'b0;
    tick();
    n_cmp++;
    if (done8 !== 1'b0 || res8 !== 8'h00) begin
      n_err++;
      $display("FAIL rst_start: got done=%b res=%h want done=0 res=00", done8, res8);
    end
  endtask

  task automatic test_wide_mul(input logic op, input logic [15:0] er);
    int          lowcnt;
    logic [18:0] exp_v;
    unit16  = 3'd6;
    op16    = op;
    acc16   = 16'h1234;
    src16   = 16'h0100;
    start16 = 1'b1;
    sb16.push_back({er, (er == 16'h0000), 1'b0, er[15]});
    tick();
    start16 = 1'b0;
    lowcnt  = 0;
    while (!ready16 && lowcnt < 60) begin
      lowcnt++;
      tick();
    end
    n_cmp++;
    if (lowcnt !== 16) begin
      n_err++;
      $display("FAIL mul16_busy op=%b: got %0d cycles want 16", op, lowcnt);
    end
    exp_v = sb16.pop_front();
    n_cmp++;
    if (done16 !== 1'b1 || {res16, z16, c16, n16} !== exp_v) begin
      n_err++;
      $display("FAIL mul16_res op=%b: got done=%b res=%h zcn=%b%b%b want done=1 res=%h zcn=%b",
               op, done16, res16, z16, c16, n16, exp_v[18:3], exp_v[2:0]);
    end
  endtask

  task automatic test_wide_shift();
    logic [18:0] exp_v;
    unit16  = 3'd2;
    op16    = 1'b1;
    acc16   = 16'h8000;
    src16   = 16'h000F;
    start16 = 1'b1;
    sb16.push_back({16'h0001, 1'b0, 1'b0, 1'b0});
    tick();
    start16 = 1'b0;
    exp_v = sb16.pop_front();
    n_cmp++;
    if (done16 !== 1'b1 || {res16, z16, c16, n16} !== exp_v) begin
      n_err++;
      $display("FAIL shr16: got done=%b res=%h zcn=%b%b%b want done=1 res=%h zcn=%b",
               done16, res16, z16, c16, n16, exp_v[18:3], exp_v[2:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul(8'h12, 8'h34, 1'b0, 1'b0, 8'hA8);
    test_mul(8'h12, 8'h34, 1'b1, 1'b0, 8'h03);
    test_mul(8'hFF, 8'hFF, 1'b0, 1'b0, 8'h01);
    test_mul(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFE);
    test_mul(8'hA7, 8'h3B, 1'b1, 1'b1, 8'h26);
    test_mul(8'hA7, 8'h3B, 1'b0, 1'b1, 8'h7D);
    test_back_to_back();
    test_reset_during_mul();
    test_reset_start_collision();
    test_wide_mul(1'b0, 16'h3400);
    test_wide_mul(1'b1, 16'h0012);
    test_wide_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
